slv_i2c_reg_fsm: RTL and testbench

Parametrised I2C slave protocol engine. Successor to the single-byte slave FSM, adding:
- address match with NACK on mismatch
- register-pointer addressing with auto-increment
- repeated START and STOP detection in any state
- multi-byte burst read/write to a local register file
It sits between the SCL/SDA synchroniser and edge detector and the slave register bank.

---
 rtl/slv_i2c_reg_fsm_pkg.sv | 34 +++
 rtl/slv_i2c_reg_fsm_if.sv | 34 +++
 rtl/slv_i2c_reg_fsm_shift.sv | 59 +++++
 rtl/slv_i2c_reg_fsm.sv | 222 ++++++++++++++++++++++
 tb/tb_slv_i2c_reg_fsm.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slv_i2c_reg_fsm_pkg.sv
// Shared types and helpers for the I2C register-slave engine.
package slv_i2c_pkg;

  // One-hot protocol states. S_ACK is the ACK slot shared by pointer and
  // data bytes of a write; the address byte has its own slot (S_ADDR_ACK)
  // because it may have to branch into a read.
  typedef enum logic [8:0] {
    S_IDLE     = 9'h001,
    S_ADDR     = 9'h002,
    S_ADDR_ACK = 9'h004,
    S_REG      = 9'h008,
    S_WR       = 9'h010,
    S_RD       = 9'h020,
    S_RD_ACK   = 9'h040,
    S_WAIT     = 9'h080,
    S_ACK      = 9'h100
  } state_e;

  // Bit counter width: holds the value DATA_SZ.
  function automatic int cnt_w(input int dsz);
    return $clog2(dsz) + 1;
  endfunction

  // START: SDA falls while SCL is high.
  function automatic logic is_start(input logic fl_sda, input logic scl);
    return fl_sda & scl;
  endfunction

  // STOP: SDA rises while SCL is high.
  function automatic logic is_stop(input logic rs_sda, input logic scl);
    return rs_sda & scl;
  endfunction

endpackage

// File: rtl/slv_i2c_reg_fsm_if.sv
// Bus bundle between the SCL/SDA edge detector, the slave engine and the
// register bank.
interface slv_i2c_reg_fsm_if #(
  parameter int DATA_SZ = 8,
  parameter int REG_AW  = 8
);
  logic               I_SCL;
  logic               I_SDA;
  logic               I_RS_SCL;
  logic               I_FL_SCL;
  logic               I_RS_SDA;
  logic               I_FL_SDA;
  logic [DATA_SZ-1:0] I_RD_DATA;
  logic               O_SDA;
  logic               O_BUSY;
  logic [REG_AW-1:0]  O_REG_ADDR;
  logic [DATA_SZ-1:0] O_WR_DATA;
  logic               O_WR_EN;
  logic               O_RD_REQ;
  logic               O_ACK_MSTR;
  logic               O_STOP;

  modport slave (
    input  I_SCL, I_SDA, I_RS_SCL, I_FL_SCL, I_RS_SDA, I_FL_SDA, I_RD_DATA,
    output O_SDA, O_BUSY, O_REG_ADDR, O_WR_DATA, O_WR_EN, O_RD_REQ,
           O_ACK_MSTR, O_STOP
  );

  modport master (
    output I_SCL, I_SDA, I_RS_SCL, I_FL_SCL, I_RS_SDA, I_FL_SDA, I_RD_DATA,
    input  O_SDA, O_BUSY, O_REG_ADDR, O_WR_DATA, O_WR_EN, O_RD_REQ,
           O_ACK_MSTR, O_STOP
  );
endinterface

// File: rtl/slv_i2c_reg_fsm_shift.sv
// Byte shift register plus remaining-bit counter. The counter reloads to
// DATA_SZ on every completed byte, so it never reaches zero once a START
// has initialised it.
module slv_i2c_shift
  import slv_i2c_pkg::*;
#(
  parameter int DATA_SZ = 8
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               init_i,       // START: restart the bit count
  input  logic               load_i,       // load a byte to transmit
  input  logic               shift_in_i,   // sample sdi_i into the LSB
  input  logic               shift_out_i,  // advance to the next TX bit
  input  logic               sdi_i,
  input  logic [DATA_SZ-1:0] din_i,
  output logic [DATA_SZ-1:0] byte_o,       // byte including the bit on sdi_i
  output logic               sdo_nxt_o,    // TX bit that follows the MSB
  output logic               byte_done_o   // the next shift ends the byte
);
  localparam int            CW   = cnt_w(DATA_SZ);
  localparam logic [CW-1:0] FULL = CW'(DATA_SZ);

  logic [DATA_SZ-1:0] sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               unused_msb;

  assign byte_done_o = (cnt_q == CW'(1));
  assign byte_o      = {sr_q[DATA_SZ-2:0], sdi_i};
  assign sdo_nxt_o   = sr_q[DATA_SZ-2];
  // The MSB is consumed straight from din_i when a byte is loaded.
  assign unused_msb  = sr_q[DATA_SZ-1];

  // Next shift-register and counter value.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (init_i) begin
      cnt_d = FULL;
    end else if (load_i) begin
      sr_d  = din_i;
      cnt_d = FULL;
    end else if (shift_in_i || shift_out_i) begin
      sr_d  = {sr_q[DATA_SZ-2:0], shift_in_i & sdi_i};
      cnt_d = (cnt_q <= CW'(1)) ? FULL : cnt_q - CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/slv_i2c_reg_fsm.sv
// I2C slave protocol engine: address match, register pointer with optional
// auto-increment, burst read/write to a local register bank. START/STOP are
// honoured in every state and win over same-cycle SCL strobes.
module slv_i2c_reg_fsm
  import slv_i2c_pkg::*;
#(
  parameter int         DATA_SZ  = 8,
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         REG_AW   = 8,
  parameter int         AUTO_INC = 1
) (
  input logic              CLK,
  input logic              RST_n,
  slv_i2c_reg_fsm_if.slave bus
);
  state_e             st_q, st_d;
  logic               rw_q, rw_d;
  logic               slot_q, slot_d;     // ACK slot: 0 = before drive, 1 = driving/acked
  logic               fromwr_q, fromwr_d; // slot belongs to a data byte
  logic               sda_q, sda_d;
  logic               busy_q, busy_d;
  logic [REG_AW-1:0]  ptr_q, ptr_d;
  logic [DATA_SZ-1:0] wdat_q, wdat_d;
  logic               wen_q, wen_d;
  logic               rreq_q, rreq_d;
  logic               ackm_q, ackm_d;
  logic               stop_q, stop_d;

  logic               sh_init, sh_load, sh_in, sh_out;
  logic [DATA_SZ-1:0] sh_byte;
  logic               sh_sdo_nxt, sh_last;
  logic               start_c, stop_c;

  assign start_c = is_start(bus.I_FL_SDA, bus.I_SCL);
  assign stop_c  = is_stop(bus.I_RS_SDA, bus.I_SCL);

  slv_i2c_shift #(.DATA_SZ(DATA_SZ)) u_shift (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .init_i      (sh_init),
    .load_i      (sh_load),
    .shift_in_i  (sh_in),
    .shift_out_i (sh_out),
    .sdi_i       (bus.I_SDA),
    .din_i       (bus.I_RD_DATA),
    .byte_o      (sh_byte),
    .sdo_nxt_o   (sh_sdo_nxt),
    .byte_done_o (sh_last)
  );

  // Next state and registered outputs; bus conditions first.
  always_comb begin
    st_d     = st_q;
    rw_d     = rw_q;
    slot_d   = slot_q;
    fromwr_d = fromwr_q;
    sda_d    = sda_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    wdat_d   = wdat_q;
    wen_d    = 1'b0;
    rreq_d   = 1'b0;
    ackm_d   = ackm_q;
    stop_d   = 1'b0;
    sh_init  = 1'b0;
    sh_load  = 1'b0;
    sh_in    = 1'b0;
    sh_out   = 1'b0;

    if (start_c) begin
      st_d    = S_ADDR;
      sda_d   = 1'b1;
      busy_d  = 1'b1;
      slot_d  = 1'b0;
      sh_init = 1'b1;
    end else if (stop_c) begin
      st_d   = S_IDLE;
      sda_d  = 1'b1;
      busy_d = 1'b0;
      slot_d = 1'b0;
      stop_d = 1'b1;
    end else begin
      case (st_q)
        S_IDLE, S_WAIT: ;
        S_ADDR: if (bus.I_RS_SCL) begin
          sh_in = 1'b1;
          if (sh_last) begin
            if (sh_byte[7:1] == SLV_ADDR) begin
              st_d   = S_ADDR_ACK;
              rw_d   = sh_byte[0];
              rreq_d = sh_byte[0]; // data is fetched during the ACK slot
              slot_d = 1'b0;
            end else begin
              st_d = S_WAIT;
            end
          end
        end
        S_ADDR_ACK: if (bus.I_FL_SCL) begin
          if (!slot_q) begin
            sda_d  = 1'b0;
            slot_d = 1'b1;
          end else begin
            slot_d = 1'b0;
            if (rw_q) begin
              sh_load = 1'b1;
              sda_d   = bus.I_RD_DATA[DATA_SZ-1];
              st_d    = S_RD;
            end else begin
              sda_d = 1'b1;
              st_d  = S_REG;
            end
          end
        end
        S_REG: if (bus.I_RS_SCL) begin
          sh_in = 1'b1;
          if (sh_last) begin
            ptr_d    = sh_byte[REG_AW-1:0];
            fromwr_d = 1'b0;
            slot_d   = 1'b0;
            st_d     = S_ACK;
          end
        end
        S_WR: if (bus.I_RS_SCL) begin
          sh_in = 1'b1;
          if (sh_last) begin
            wdat_d   = sh_byte;
            wen_d    = 1'b1;
            fromwr_d = 1'b1;
            slot_d   = 1'b0;
            st_d     = S_ACK;
          end
        end
        S_ACK: if (bus.I_FL_SCL) begin
          if (!slot_q) begin
            sda_d  = 1'b0;
            slot_d = 1'b1;
          end else begin
            sda_d  = 1'b1;
            slot_d = 1'b0;
            st_d   = S_WR;
            // Bump only after the write strobe so it carries the old pointer.
            if (fromwr_q && (AUTO_INC != 0)) ptr_d = ptr_q + REG_AW'(1);
          end
        end
        S_RD: if (bus.I_FL_SCL) begin
          sh_out = 1'b1;
          if (sh_last) begin
            sda_d  = 1'b1;
            slot_d = 1'b0;
            st_d   = S_RD_ACK;
          end else begin
            sda_d = sh_sdo_nxt;
          end
        end
        S_RD_ACK: begin
          if (!slot_q) begin
            if (bus.I_RS_SCL) begin
              ackm_d = bus.I_SDA;
              if (!bus.I_SDA) begin
                slot_d = 1'b1;
                rreq_d = 1'b1;
                if (AUTO_INC != 0) ptr_d = ptr_q + REG_AW'(1);
              end else begin
                sda_d = 1'b1;
                st_d  = S_WAIT;
              end
            end
          end else if (bus.I_FL_SCL) begin
            sh_load = 1'b1;
            sda_d   = bus.I_RD_DATA[DATA_SZ-1];
            slot_d  = 1'b0;
            st_d    = S_RD;
          end
        end
        default: begin
          st_d  = S_IDLE;
          sda_d = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      st_q     <= S_IDLE;
      rw_q     <= 1'b0;
      slot_q   <= 1'b0;
      fromwr_q <= 1'b0;
      sda_q    <= 1'b1;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
      wdat_q   <= '0;
      wen_q    <= 1'b0;
      rreq_q   <= 1'b0;
      ackm_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      rw_q     <= rw_d;
      slot_q   <= slot_d;
      fromwr_q <= fromwr_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      wdat_q   <= wdat_d;
      wen_q    <= wen_d;
      rreq_q   <= rreq_d;
      ackm_q   <= ackm_d;
      stop_q   <= stop_d;
    end
  end

  assign bus.O_SDA      = sda_q;
  assign bus.O_BUSY     = busy_q;
  assign bus.O_REG_ADDR = ptr_q;
  assign bus.O_WR_DATA  = wdat_q;
  assign bus.O_WR_EN    = wen_q;
  assign bus.O_RD_REQ   = rreq_q;
  assign bus.O_ACK_MSTR = ackm_q;
  assign bus.O_STOP     = stop_q;
endmodule

// File: tb/tb_slv_i2c_reg_fsm.sv
// Bit-banged I2C master, wired-AND bus, register bank and a
// transaction-level model of the slave's pointer and memory.
module tb_slv_i2c_reg_fsm;
  localparam int         DSZ = 8;
  localparam int         AW  = 8;
  localparam logic [6:0] ADR = 7'h50;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  slv_i2c_reg_fsm_if #(.DATA_SZ(DSZ), .REG_AW(AW)) bus();

  slv_i2c_reg_fsm #(.DATA_SZ(DSZ), .SLV_ADDR(ADR), .REG_AW(AW), .AUTO_INC(1)) dut (
    .CLK(CLK), .RST_n(RST_n), .bus(bus)
  );

  int n_chk = 0, n_err = 0;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic load_bank = 1'b0;
  logic [7:0] ref_mem [256];
  logic [7:0] bank_mem [256];
  logic [7:0] ref_ptr;
  logic [7:0] cap_a [1024];
  logic [7:0] cap_d [1024];
  int wr_n = 0, rreq_cnt = 0, stop_cnt = 0, both_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchroniser/edge detector stand-in: wired-AND line, one-CLK strobes.
  always @(negedge CLK) begin
    logic ln;
    ln = sda_m & bus.O_SDA;
    bus.I_RS_SCL = scl_m & ~bus.I_SCL;
    bus.I_FL_SCL = ~scl_m & bus.I_SCL;
    bus.I_RS_SDA = ln & ~bus.I_SDA;
    bus.I_FL_SDA = ~ln & bus.I_SDA;
    bus.I_SCL    = scl_m;
    bus.I_SDA    = ln;
  end

  // Register bank: read data one CLK after the request.
  always @(posedge CLK) begin
    if (load_bank) for (int i = 0; i < 256; i++) bank_mem[i] <= ref_mem[i];
    else if (bus.O_WR_EN) bank_mem[bus.O_REG_ADDR] <= bus.O_WR_DATA;
    if (!RST_n) bus.I_RD_DATA <= '0;
    else if (bus.O_RD_REQ) bus.I_RD_DATA <= bank_mem[bus.O_REG_ADDR];
  end

  // Output event monitor.
  always @(negedge CLK) begin
    if (RST_n) begin
      if (bus.O_WR_EN) begin
        if (wr_n < 1024) begin
          cap_a[wr_n] = bus.O_REG_ADDR;
          cap_d[wr_n] = bus.O_WR_DATA;
        end
        wr_n++;
      end
      if (bus.O_RD_REQ) rreq_cnt++;
      if (bus.O_WR_EN && bus.O_RD_REQ) both_cnt++;
      if (bus.O_STOP) stop_cnt++;
    end
  end

  task automatic hold();
    repeat (3) @(posedge CLK);
    #1;
  endtask
  task automatic setscl(input logic v); scl_m = v; hold(); endtask
  task automatic setsda(input logic v); sda_m = v; hold(); endtask

  task automatic start_c();
    setscl(0); setsda(1); setscl(1); setsda(0); setscl(0);
  endtask
  task automatic stop_c();
    setscl(0); setsda(0); setscl(1); setsda(1);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      setscl(0); setsda(b[i]); setscl(1);
    end
    setscl(0); setsda(1); setscl(1);
    ack = bus.I_SDA;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      setscl(0); setsda(1); setscl(1);
      b[i] = bus.I_SDA;
    end
    setscl(0); setsda(mack); setscl(1);
  endtask

  // Write transaction: address, pointer, n data bytes (from dat), optional
  // partial byte of 3 bits before STOP.
  task automatic do_write(input logic [6:0] a, input logic [7:0] ptr, input int n,
                          input logic [31:0] dat, input logic mid_stop);
    int base_wr, base_rq, base_st;
    logic ack;
    logic [7:0] d, p;
    logic [7:0] ea [$];
    logic [7:0] ed [$];
    base_wr = wr_n; base_rq = rreq_cnt; base_st = stop_cnt;
    start_c();
    chk("busy_start", bus.O_BUSY, 1);
    wr_byte({a, 1'b0}, ack);
    chk("addr_ack", ack, (a == ADR) ? 0 : 1);
    if (a == ADR) begin
      wr_byte(ptr, ack);
      chk("ptr_ack", ack, 0);
      p = ptr;
      for (int k = 0; k < n; k++) begin
        d = dat[8*k +: 8];
        wr_byte(d, ack);
        chk("data_ack", ack, 0);
        ea.push_back(p); ed.push_back(d);
        ref_mem[p] = d;
        p = p + 8'd1;
      end
      ref_ptr = p;
      if (mid_stop) begin
        d = 8'($urandom);
        for (int i = 7; i >= 5; i--) begin
          setscl(0); setsda(d[i]); setscl(1);
        end
      end
    end else begin
      wr_byte(8'($urandom), ack);
      chk("wait_nack", ack, 1);
      chk("wait_busy", bus.O_BUSY, 1);
    end
    stop_c();
    chk("stop_busy", bus.O_BUSY, 0);
    chk("stop_pulse", stop_cnt - base_st, 1);
    chk("sda_idle", bus.O_SDA, 1);
    chk("wr_cnt", wr_n - base_wr, ea.size());
    for (int k = 0; k < ea.size(); k++)
      if (base_wr + k < wr_n && base_wr + k < 1024) begin
        chk("wr_addr", cap_a[base_wr+k], ea[k]);
        chk("wr_data", cap_d[base_wr+k], ed[k]);
      end
    chk("wr_no_rdreq", rreq_cnt - base_rq, 0);
    chk("ptr_after_wr", bus.O_REG_ADDR, ref_ptr);
  endtask

  // Random read: set pointer, repeated START, n bytes, NACK on the last.
  task automatic do_read(input logic [7:0] ptr, input int n);
    int base_rq;
    logic ack;
    logic [7:0] b;
    start_c();
    wr_byte({ADR, 1'b0}, ack);
    chk("rd_waddr_ack", ack, 0);
    wr_byte(ptr, ack);
    chk("rd_ptr_ack", ack, 0);
    chk("ptr_set", bus.O_REG_ADDR, ptr);
    ref_ptr = ptr;
    base_rq = rreq_cnt;
    start_c();
    wr_byte({ADR, 1'b1}, ack);
    chk("rd_raddr_ack", ack, 0);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n-1, b);
      chk("rd_data", b, ref_mem[ref_ptr]);
      if (k != n-1) ref_ptr = ref_ptr + 8'd1;
    end
    chk("ack_mstr", bus.O_ACK_MSTR, 1);
    chk("nack_release", bus.O_SDA, 1);
    chk("rd_req_cnt", rreq_cnt - base_rq, n);
    stop_c();
    chk("rd_stop_busy", bus.O_BUSY, 0);
    chk("ptr_after_rd", bus.O_REG_ADDR, ref_ptr);
  endtask

  initial begin
    logic ack;
    logic [6:0] bad;
    bus.I_SCL = 1'b1; bus.I_SDA = 1'b1;
    bus.I_RS_SCL = 1'b0; bus.I_FL_SCL = 1'b0; bus.I_RS_SDA = 1'b0; bus.I_FL_SDA = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[5] = 8'h3C; ref_mem[6] = 8'h3D;
    ref_ptr = 8'h00;
    load_bank = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    load_bank = 1'b0;
    chk("rst_sda", bus.O_SDA, 1);
    chk("rst_outs", {bus.O_BUSY, bus.O_WR_EN, bus.O_RD_REQ, bus.O_ACK_MSTR, bus.O_STOP,
                     bus.O_REG_ADDR, bus.O_WR_DATA}, 0);
    RST_n = 1'b1;
    hold();

    // Directed: burst write, random read, mismatch, wrap, mid-byte STOP.
    do_write(ADR, 8'h10, 2, 32'h0000_2211, 1'b0);
    do_read(8'h05, 2);
    do_write(7'h51, 8'h00, 0, 32'h0, 1'b0);
    do_write(ADR, 8'hFF, 2, $urandom, 1'b0);
    do_write(ADR, 8'($urandom), 1, $urandom, 1'b1);

    // Reset while the slave pulls SDA low in the address ACK slot.
    start_c();
    wr_byte({ADR, 1'b1}, ack);
    chk("pre_rst_sda", bus.O_SDA, 0);
    RST_n = 1'b0;
    #1;
    chk("rst_async_sda", bus.O_SDA, 1);
    chk("rst_mid_outs", {bus.O_BUSY, bus.O_WR_EN, bus.O_RD_REQ, bus.O_ACK_MSTR, bus.O_STOP,
                         bus.O_REG_ADDR, bus.O_WR_DATA}, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    hold();
    RST_n = 1'b1;
    ref_ptr = 8'h00;
    hold();
    do_write(ADR, 8'($urandom), 2, $urandom, 1'b0);

    // Random transactions.
    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 2))
        0: do_write(ADR, 8'($urandom), $urandom_range(1, 4), $urandom, 1'b0);
        1: do_read(8'($urandom), $urandom_range(1, 3));
        default: begin
          bad = 7'($urandom);
          if (bad == ADR) bad = bad ^ 7'h01;
          do_write(bad, 8'h00, 0, 32'h0, 1'b0);
        end
      endcase
    end

    chk("wr_rd_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
